// File: rtl/mopshub_bus_scheduler_if.sv
// mopshub_bus_scheduler_if: request/grant bundle between the per-bus
// requesters, the round-robin scheduler and the shared CAN tx engine.
//
// Handshake: the scheduler raises start_tx for exactly one cycle to launch the
// engine for the bus named by bus_sel/grant. grant and bus_sel are stable from
// that pulse until the engine answers with a one-cycle tx_done pulse (or the
// optional watchdog aborts). There is no backpressure: req is a level per bus
// and is only consumed when that bus is granted. A tx_done that arrives while
// no transaction is outstanding is ignored.
interface mopshub_bus_scheduler_if #(
  parameter int N_BUSES = 32
);
  logic               enable;
  logic [N_BUSES-1:0] req;
  logic [N_BUSES-1:0] bus_mask;
  logic               tx_done;
  logic               start_tx;
  logic [N_BUSES-1:0] grant;
  logic [4:0]         bus_sel;
  logic               busy;
  logic [15:0]        txn_cnt;
  logic               timeout;
  logic [2:0]         dbg_state;

  // Scheduler side
  modport slave (
    input  enable, req, bus_mask, tx_done,
    output start_tx, grant, bus_sel, busy, txn_cnt, timeout, dbg_state
  );

  // Requester / engine side
  modport master (
    output enable, req, bus_mask, tx_done,
    input  start_tx, grant, bus_sel, busy, txn_cnt, timeout, dbg_state
  );
endinterface

// File: rtl/mopshub_bus_scheduler.sv
// mopshub_bus_scheduler: round-robin arbiter sharing one CAN tx engine across
// N_BUSES requesters. IDLE -> ARB -> START -> WAIT -> GAP -> IDLE.
// The bus just served is searched last, giving strict rotation under load.
// Optional watchdog on WAIT: define MOPSHUB_SCHED_TIMEOUT_EN to abort a
// transaction after TIMEOUT cycles without tx_done.
module mopshub_bus_scheduler #(
  parameter int N_BUSES    = 32,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  mopshub_bus_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam logic [5:0]         NB       = 6'(N_BUSES);
  localparam logic [N_BUSES-1:0] ONE      = {{(N_BUSES-1){1'b0}}, 1'b1};
  localparam logic [7:0]         GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam state_e             POST_TXN = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_e             state_q, state_d;
  logic [4:0]         ptr_q, ptr_d;
  logic [4:0]         sel_q, sel_d;
  logic [N_BUSES-1:0] grant_q, grant_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         gap_q, gap_d;

  logic [N_BUSES-1:0] elig;
  logic               win_found;
  logic [4:0]         win_idx;
  logic [5:0]         cand;
  logic [5:0]         sel_inc;
  logic [4:0]         ptr_after;
  logic               wd_expire;

  assign elig      = bus.req & bus.bus_mask;
  assign sel_inc   = {1'b0, sel_q} + 6'd1;
  assign ptr_after = (sel_inc >= NB) ? 5'd0 : sel_inc[4:0];

  // Rotating first-set search over the eligible vector, starting at ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_BUSES; i++) begin
      cand = {1'b0, ptr_q} + 6'(i);
      if (cand >= NB) cand = cand - NB;
      if (!win_found && elig[cand[4:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[4:0];
      end
    end
  end

  // Next-state and next-output logic; outputs are registered below
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && (|elig)) state_d = S_ARB;
      end
      S_ARB: begin
        if (!win_found) begin
          state_d = S_IDLE;
        end else begin
          sel_d   = win_idx;
          grant_d = ONE << win_idx;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          grant_d = '0;
          cnt_d   = cnt_q + 16'd1;
          ptr_d   = ptr_after;
          gap_d   = GAP_LOAD;
          state_d = POST_TXN;
        end else if (wd_expire) begin
          grant_d = '0;
          ptr_d   = ptr_after;
          gap_d   = GAP_LOAD;
          state_d = POST_TXN;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

`ifdef MOPSHUB_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Watchdog: counts WAIT cycles, fires when TIMEOUT elapse without tx_done
  always_comb begin
    wd_expire = (state_q == S_WAIT) && !bus.tx_done && (wd_q == WD_LAST);
    wd_d      = ((state_q == S_WAIT) && !wd_expire) ? wd_q + 16'd1 : 16'd0;
    timeout_d = wd_expire;
  end

  // Watchdog counter and one-cycle abort pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.start_tx  = start_q;
  assign bus.grant     = grant_q;
  assign bus.bus_sel   = sel_q;
  assign bus.busy      = busy_q;
  assign bus.txn_cnt   = cnt_q;
  assign bus.dbg_state = state_q;

endmodule
